nibble_serial_subtractor: RTL

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

---
 rtl/nibble_serial_subtractor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_subtractor.sv
// 16-bit subtractor computing A-B one nibble per clock with lookahead carry.
// Flags and difference update together on the completion edge.
module nibble_serial_subtractor (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] D,
    output logic        Bout,
    output logic        V,
    output logic        N,
    output logic        Z,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] res_q;
    logic [1:0]  idx;
    logic        carry;

    logic        accept;
    logic        last;
    logic [3:0]  an;
    logic [3:0]  bn;
    logic [3:0]  p;
    logic [3:0]  g;
    logic [3:0]  sum;
    logic        c1;
    logic        c2;
    logic        c3;
    logic        gg;
    logic        gp;
    logic        cout;
    logic [15:0] d_fin;

    // DONE exits on its edge, so a Start seen there begins the next operation
    assign accept = Start && (state == IDLE || state == DONE);
    assign last   = (state == RUN) && (idx == 2'd3);

    assign an = a_q[{idx, 2'b00} +: 4];
    assign bn = ~b_q[{idx, 2'b00} +: 4];
    assign p  = an ^ bn;
    assign g  = an & bn;

    assign c1 = g[0] | (p[0] & carry);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry);
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign gp   = &p;
    assign cout = gg | (gp & carry);
    assign sum  = p ^ {c3, c2, c1, carry};

    assign d_fin = {sum, res_q[11:0]};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (idx == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = Start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            idx   <= '0;
            carry <= 1'b0;
            D     <= '0;
            Bout  <= 1'b0;
            V     <= 1'b0;
            N     <= 1'b0;
            Z     <= 1'b1;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            idx   <= 2'd0;
            carry <= 1'b1;
        end else if (state == RUN) begin
            res_q[{idx, 2'b00} +: 4] <= sum;
            carry <= cout;
            idx   <= idx + 2'd1;
            if (last) begin
                D    <= d_fin;
                Bout <= ~cout;
                V    <= (a_q[15] != b_q[15]) && (d_fin[15] != a_q[15]);
                N    <= d_fin[15];
                Z    <= (d_fin == 16'd0);
            end
        end
    end

    assign Busy = (state == RUN);
    assign Done = (state == DONE);

endmodule
